// File: rtl/mem_wr_buffer.sv
// Posted-write buffer between an AHB slave and an SRAM port: a circular FIFO of
// {addr, data} entries with a one-cycle path to the memory request.
module mem_wr_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [AW-1:0]          mem_WR_addr,
  input  logic                   mem_write_flag,
  input  logic [DW-1:0]          HWDATA_toMem,
  output logic                   sram_req,
  output logic [AW-1:0]          sram_addr,
  output logic [DW-1:0]          sram_wdata,
  input  logic                   sram_ack,
  output logic                   buf_full,
  output logic                   buf_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          push, pop;

  always_comb begin
    pop      = (count_q != '0) && sram_ack;
    // A full buffer still accepts a write when the head leaves in the same cycle.
    push     = mem_write_flag && ((count_q != CW'(DEPTH)) || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (mem_write_flag & ~push);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Entry storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge HCLK) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= mem_WR_addr;
      data_mem[wr_ptr_q] <= HWDATA_toMem;
    end
  end

  assign sram_req   = (count_q != '0);
  assign sram_addr  = addr_mem[rd_ptr_q];
  assign sram_wdata = data_mem[rd_ptr_q];
  assign buf_full   = (count_q == CW'(DEPTH));
  assign buf_empty  = (count_q == '0);
  assign count      = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_mem_wr_buffer.sv
// Scoreboard bench for mem_wr_buffer: a queue model predicts every presented
// entry, the occupancy flags and the sticky overflow.
module tb_mem_wr_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [AW-1:0] mem_WR_addr;
  logic          mem_write_flag;
  logic [DW-1:0] HWDATA_toMem;
  logic          sram_req;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          sram_ack;
  logic          buf_full, buf_empty, overflow;
  logic [2:0]    count;

  mem_wr_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .mem_WR_addr(mem_WR_addr),
    .mem_write_flag(mem_write_flag), .HWDATA_toMem(HWDATA_toMem),
    .sram_req(sram_req), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_ack(sram_ack), .buf_full(buf_full), .buf_empty(buf_empty),
    .count(count), .overflow(overflow)
  );

  always #5 HCLK = ~HCLK;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t q[$];
  logic movf = 1'b0;
  int   max_cnt = 0;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model steps on the falling edge, predicting the next rising edge.
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      q.delete();
      movf = 1'b0;
      chk("rst_req",   sram_req,  0);
      chk("rst_cnt",   count,     0);
      chk("rst_empty", buf_empty, 1);
      chk("rst_full",  buf_full,  0);
      chk("rst_ovf",   overflow,  0);
    end else begin
      logic p;
      chk("req",   sram_req,  q.size() != 0);
      chk("cnt",   count,     q.size());
      chk("full",  buf_full,  q.size() == DEPTH);
      chk("empty", buf_empty, q.size() == 0);
      chk("ovf",   overflow,  movf);
      if (q.size() > max_cnt) max_cnt = q.size();
      p = (q.size() != 0) && sram_ack;
      if (q.size() != 0) begin
        chk("addr", sram_addr,  q[0].a);
        chk("data", sram_wdata, q[0].d);
      end
      if (p) void'(q.pop_front());
      if (mem_write_flag) begin
        if (q.size() < DEPTH) q.push_back('{a: mem_WR_addr, d: HWDATA_toMem});
        else movf = 1'b1;
      end
    end
  end

  task automatic cyc(input logic wf, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic ack);
    mem_write_flag = wf;
    mem_WR_addr    = a;
    HWDATA_toMem   = d;
    sram_ack       = ack;
    @(posedge HCLK);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      cyc(1'b0, '0, '0, 1'b1);
    end
    cyc(1'b0, '0, '0, 1'b1);
    chk("drain_done", q.size(), 0);
  endtask

  task automatic do_reset(input int cycles);
    HRESETn = 1'b0;
    #1;
    chk("rst_now_req", sram_req, 0);
    chk("rst_now_cnt", count,    0);
    for (int i = 0; i < cycles; i++) cyc(1'b0, '0, '0, 1'b0);
    HRESETn = 1'b1;
  endtask

  initial begin
    HRESETn = 1'b0;
    mem_write_flag = 1'b0;
    mem_WR_addr = '0;
    HWDATA_toMem = '0;
    sram_ack = 1'b0;
    @(posedge HCLK); #1;
    do_reset(2);

    // single write, ack tied high
    cyc(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1);

    // fill then drain in order
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), 32'(i + 1), 1'b0);
    cyc(1'b0, '0, '0, 1'b0);
    chk("fill_full", buf_full, 1);
    drain();

    // overflow: fifth write while full and stalled is dropped
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), 32'(i + 1), 1'b0);
    cyc(1'b1, 32'h10, 32'd5, 1'b0);
    drain();
    chk("ovf_sticky", overflow, 1);

    // full with push and pop together
    do_reset(1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'(i * 4), 32'(i + 1), 1'b0);
    cyc(1'b1, 32'h20, 32'd9, 1'b1);
    chk("pp_cnt", count, 4);
    chk("pp_ovf", overflow, 0);
    drain();

    // wrap: back-to-back writes with continuous ack
    max_cnt = 0;
    for (int i = 0; i < 10; i++) cyc(1'b1, 32'h100 + 32'(i * 4), 32'(100 + i), 1'b1);
    drain();
    chk("wrap_max_cnt", max_cnt, 1);

    // reset in the middle of a drain
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h30 + 32'(i * 4), 32'(20 + i), 1'b0);
    cyc(1'b0, '0, '0, 1'b1);
    do_reset(2);
    cyc(1'b1, 32'h40, 32'd7, 1'b1);
    chk("post_rst_addr", sram_addr, 32'h40);
    chk("post_rst_data", sram_wdata, 32'd7);
    drain();

    // random traffic
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 2) != 0));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_wr_buffer.md
MEM_WR_BUFFER -- requirements
Module: mem_wr_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of write entries; power of two, minimum 2.
REQ-002 Parameter AW, default 32, address width.
REQ-003 Parameter DW, default 32, data width.
REQ-004 HCLK  input  1  sole clock; all state updates on its rising edge.
REQ-005 HRESETn  input  1  reset, asynchronous assert, active-low.
REQ-006 mem_WR_addr  input  AW  write address from the upstream AHB slave.
REQ-007 mem_write_flag  input  1  write strobe from the slave; one write per cycle while high.
REQ-008 HWDATA_toMem  input  DW  write data, valid with mem_write_flag.
REQ-009 sram_req  output  1  head entry valid and presented to memory.
REQ-010 sram_addr  output  AW  head entry address.
REQ-011 sram_wdata  output  DW  head entry data.
REQ-012 sram_ack  input  1  memory accepts the head entry this cycle.
REQ-013 buf_full  output  1  count == DEPTH; the integrator uses it to drive HREADY low.
REQ-014 buf_empty  output  1  count == 0.
REQ-015 count  output  log2(DEPTH)+1  number of occupied entries.
REQ-016 overflow  output  1  sticky flag: a write was dropped.

Function
REQ-017 Storage is a circular buffer of DEPTH {addr, data} entries with wr_ptr and rd_ptr, each log2(DEPTH) bits wide and wrapping DEPTH-1 -> 0.
REQ-018 push: mem_write_flag=1 and (count<DEPTH, or pop in the same cycle); the entry is written at wr_ptr and wr_ptr increments.
REQ-019 pop: sram_req=1 and sram_ack=1; rd_ptr increments.
REQ-020 count next value: +1 on push only, -1 on pop only, unchanged on push+pop or on neither.
REQ-021 sram_req = (count != 0); sram_addr and sram_wdata come from the entry at rd_ptr and hold stable while sram_req=1 and sram_ack=0.
REQ-022 Latency: a push into an empty buffer at edge N gives sram_req=1 with that entry's data in the cycle after edge N, i.e. one cycle.
REQ-023 Ordering is strict FIFO; entries are never reordered, merged or dropped except under REQ-025.
REQ-024 Full with simultaneous push and pop: both take effect; count stays DEPTH and the new entry is accepted.
REQ-025 Full with push and no pop: the write is dropped, storage and pointers are unchanged, and overflow is set to 1.
REQ-026 overflow stays set until reset.
REQ-027 Empty with push: the pop condition is impossible that cycle because sram_req=0; no bypass path exists.
REQ-028 sram_ack while sram_req=0 is ignored; pointers and count are unchanged.
REQ-029 buf_full and buf_empty are decoded from registered count; no combinational path runs from mem_write_flag to any output.
REQ-030 Address and data are forwarded unmodified; no alignment check and no HSIZE handling.

Reset
REQ-031 When HRESETn=0, asynchronously: wr_ptr=0, rd_ptr=0, count=0, overflow=0, sram_req=0, buf_empty=1, buf_full=0.
REQ-032 Storage contents are not reset; sram_addr and sram_wdata are don't-care while sram_req=0.
REQ-033 Reset asserted mid-operation discards all pending entries; the first write after release is presented first.
REQ-034 Reset deasserts synchronously to HCLK in the integrating design; the block takes no action on the rising edge of HRESETn.

Verification
REQ-035 Single write: addr 0x0000_0010, data 0xDEAD_BEEF, sram_ack tied 1 -> sram_req one cycle later with those values; count 1 then 0; buf_empty returns to 1.
REQ-036 Fill and drain: 4 writes (addr 0x0/0x4/0x8/0xC, data 1..4), sram_ack=0 -> count=4, buf_full=1; then sram_ack=1 -> outputs 0x0,0x4,0x8,0xC in order over 4 cycles.
REQ-037 Overflow: full buffer, 5th write (0x10, data 5), sram_ack=0 -> dropped, overflow=1, count=4; drain yields data 1..4 only; overflow stays 1.
REQ-038 Full push+pop: full, write 0x20/data 9 with sram_ack=1 -> count stays 4, overflow=0; 0x20/9 emerges 4th after the pop.
REQ-039 Wrap: 10 back-to-back writes with sram_ack=1 continuously -> all 10 presented in order, no loss, count never exceeds 2.
REQ-040 Reset mid-drain: 3 entries pending, HRESETn low 2 cycles -> sram_req=0 and count=0 immediately; next write 0x40/data 7 is the first presented.
